// File: rtl/dp_controller.sv
// Multicycle control FSM for the ARM32 datapath: accepts one data-processing
// instruction, checks legality and condition, then sequences load/execute/write-back.
module dp_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] status_out,
  output logic        waiting,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  w_addr1,
  output logic        w_en1,
  output logic [3:0]  w_addr2,
  output logic        w_en2,
  output logic [3:0]  A_addr,
  output logic [3:0]  B_addr,
  output logic [3:0]  shift_addr,
  output logic [1:0]  sel_A_in,
  output logic [1:0]  sel_B_in,
  output logic        sel_shift_in,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic [31:0] shift_imme,
  output logic        sel_shift,
  output logic [1:0]  shift_op,
  output logic        sel_A,
  output logic        sel_B,
  output logic        sel_post_shift,
  output logic [31:0] imme_data,
  output logic [2:0]  ALU_op,
  output logic        en_status
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] ir;
  logic        ill_q;

  logic [3:0]  cond, opcode, rn, rd;
  logic        i_bit, s_bit;
  logic        supported, is_cmp, is_mov, dec_illegal, cond_pass, go;
  logic [2:0]  alu_sel;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic [63:0] imm_dbl;
  logic        status_unused;

  assign cond   = ir[31:28];
  assign i_bit  = ir[25];
  assign opcode = ir[24:21];
  assign s_bit  = ir[20];
  assign rn     = ir[19:16];
  assign rd     = ir[15:12];

  assign flag_n = status_out[31];
  assign flag_z = status_out[30];
  assign flag_c = status_out[29];
  assign flag_v = status_out[28];
  assign status_unused = ^status_out[27:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) ir <= instr;
      if (state == DECODE) ill_q <= dec_illegal;
    end
  end

  always_comb begin
    supported = 1'b1;
    alu_sel   = 3'b000;
    case (opcode)
      4'b0000: alu_sel = 3'b011;
      4'b0001: alu_sel = 3'b101;
      4'b0010: alu_sel = 3'b001;
      4'b0100: alu_sel = 3'b000;
      4'b1010: alu_sel = 3'b001;
      4'b1100: alu_sel = 3'b100;
      4'b1101: alu_sel = 3'b000;
      default: supported = 1'b0;
    endcase
  end

  assign is_cmp = (opcode == 4'b1010);
  assign is_mov = (opcode == 4'b1101);

  // Register-shift form with Rs=PC is rejected only for the register operand (I=0).
  assign dec_illegal = (ir[27:26] != 2'b00) || !supported || (cond == 4'b1111) ||
                       (!is_cmp && rd == 4'd15) ||
                       (!i_bit && ir[4] && ir[11:8] == 4'd15);

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign go = !dec_illegal && cond_pass;

  // Rotate-right of the 8-bit immediate by doubling the word and shifting.
  assign imm_dbl = {24'b0, ir[7:0], 24'b0, ir[7:0]} >> {ir[11:8], 1'b0};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = DECODE;
      DECODE:  state_nx = go ? EXEC : DONE;
      EXEC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    waiting        = 1'b0;
    done           = 1'b0;
    illegal        = 1'b0;
    w_addr1        = '0;
    w_en1          = 1'b0;
    w_addr2        = '0;
    w_en2          = 1'b0;
    A_addr         = '0;
    B_addr         = '0;
    shift_addr     = '0;
    sel_A_in       = '0;
    sel_B_in       = '0;
    sel_shift_in   = 1'b0;
    en_A           = 1'b0;
    en_B           = 1'b0;
    en_S           = 1'b0;
    shift_imme     = '0;
    sel_shift      = 1'b0;
    shift_op       = '0;
    sel_A          = 1'b0;
    sel_B          = 1'b0;
    sel_post_shift = 1'b0;
    imme_data      = '0;
    ALU_op         = '0;
    en_status      = 1'b0;
    case (state)
      IDLE: waiting = 1'b1;
      DECODE: begin
        if (go) begin
          en_A       = 1'b1;
          en_B       = 1'b1;
          en_S       = 1'b1;
          A_addr     = rn;
          B_addr     = ir[3:0];
          shift_addr = ir[11:8];
          sel_shift  = i_bit ? 1'b0 : ir[4];
          shift_imme = {27'b0, ir[11:7]};
        end
      end
      EXEC: begin
        shift_op  = i_bit ? 2'b00 : ir[6:5];
        sel_B     = i_bit;
        imme_data = imm_dbl[31:0];
        sel_A     = is_mov;
        ALU_op    = alu_sel;
        en_status = s_bit || is_cmp;
        w_en1     = !is_cmp;
        w_addr1   = is_cmp ? 4'd0 : rd;
      end
      DONE: begin
        done    = 1'b1;
        illegal = ill_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dp_controller.sv
// Self-checking bench for dp_controller: directed cases plus randomized
// instructions checked against a behavioural model of the instruction rules.
module tb_dp_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] status_out = '0;
  logic        waiting, done, illegal, w_en1, w_en2, sel_shift_in;
  logic [3:0]  w_addr1, w_addr2, A_addr, B_addr, shift_addr;
  logic [1:0]  sel_A_in, sel_B_in, shift_op;
  logic        en_A, en_B, en_S, sel_shift, sel_A, sel_B, sel_post_shift, en_status;
  logic [31:0] shift_imme, imme_data;
  logic [2:0]  ALU_op;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic waiting, done, illegal;
    logic [3:0] w_addr1; logic w_en1; logic [3:0] w_addr2; logic w_en2;
    logic [3:0] A_addr, B_addr, shift_addr;
    logic [1:0] sel_A_in, sel_B_in;
    logic sel_shift_in, en_A, en_B, en_S;
    logic [31:0] shift_imme; logic sel_shift; logic [1:0] shift_op;
    logic sel_A, sel_B, sel_post_shift;
    logic [31:0] imme_data; logic [2:0] ALU_op; logic en_status;
  } ctl_t;

  logic [3:0] OPS  [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1010, 4'b1100, 4'b1101};
  logic [2:0] ALUS [7] = '{3'b011, 3'b101, 3'b001, 3'b000, 3'b001, 3'b100, 3'b000};

  dp_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .status_out(status_out),
    .waiting(waiting), .done(done), .illegal(illegal),
    .w_addr1(w_addr1), .w_en1(w_en1), .w_addr2(w_addr2), .w_en2(w_en2),
    .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr),
    .sel_A_in(sel_A_in), .sel_B_in(sel_B_in), .sel_shift_in(sel_shift_in),
    .en_A(en_A), .en_B(en_B), .en_S(en_S),
    .shift_imme(shift_imme), .sel_shift(sel_shift), .shift_op(shift_op),
    .sel_A(sel_A), .sel_B(sel_B), .sel_post_shift(sel_post_shift),
    .imme_data(imme_data), .ALU_op(ALU_op), .en_status(en_status)
  );

  always #5 clk = ~clk;

  function automatic ctl_t snap();
    ctl_t s;
    s = '{waiting, done, illegal, w_addr1, w_en1, w_addr2, w_en2, A_addr, B_addr,
          shift_addr, sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S, shift_imme,
          sel_shift, shift_op, sel_A, sel_B, sel_post_shift, imme_data, ALU_op, en_status};
    return s;
  endfunction

  // Expected per-cycle controls derived from the instruction rules.
  function automatic void model(input logic [31:0] ir, input logic [31:0] st,
                                output int dcyc, output ctl_t e1, output ctl_t e2,
                                output ctl_t e3);
    bit sup = 0, writes, ill, pass, base, n, z, c, v;
    logic [2:0] aluop = '0;
    logic [31:0] x;
    for (int k = 0; k < 7; k++) if (ir[24:21] == OPS[k]) begin sup = 1; aluop = ALUS[k]; end
    writes = (ir[24:21] != 4'b1010);
    ill = (ir[27:26] != 0) || !sup || (ir[31:28] == 4'hF) || (writes && ir[15:12] == 4'hF) ||
          (!ir[25] && ir[4] && ir[11:8] == 4'hF);
    {n, z, c, v} = st[31:28];
    case (ir[31:29])
      3'd0: base = z;            3'd1: base = c;
      3'd2: base = n;            3'd3: base = v;
      3'd4: base = c && !z;      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1;
    endcase
    pass = (ir[31:28] == 4'hE) ? 1'b1 : (ir[28] ? !base : base);
    x = {24'b0, ir[7:0]};
    for (int r = 0; r < 2 * ir[11:8]; r++) x = {x[0], x[31:1]};
    e1 = '0; e2 = '0; e3 = '0;
    if (!ill && pass) begin
      dcyc = 3;
      e1.en_A = 1; e1.en_B = 1; e1.en_S = 1;
      e1.A_addr = ir[19:16]; e1.B_addr = ir[3:0]; e1.shift_addr = ir[11:8];
      e1.sel_shift = ir[25] ? 1'b0 : ir[4];
      e1.shift_imme = 32'(ir[11:7]);
      e2.shift_op = ir[25] ? 2'b00 : ir[6:5];
      e2.sel_B = ir[25]; e2.imme_data = x; e2.sel_A = (ir[24:21] == 4'b1101);
      e2.ALU_op = aluop; e2.en_status = ir[20] || !writes;
      e2.w_en1 = writes; e2.w_addr1 = writes ? ir[15:12] : 4'd0;
      e3.done = 1;
    end else begin
      dcyc = 2;
      e2.done = 1; e2.illegal = ill;
    end
  endfunction

  // Issue one instruction from IDLE; returns the observations of cycles 1..3.
  task automatic run(input logic [31:0] ins, input logic [31:0] st, input bit busy_start,
                     input logic [31:0] alt, output ctl_t s1, output ctl_t s2,
                     output ctl_t s3, output int dcyc, output ctl_t s_after);
    instr = ins; status_out = st; start = 1;
    @(posedge clk); #1;
    start = busy_start;
    if (busy_start) instr = alt;
    s1 = snap(); s2 = '0; s3 = '0; dcyc = s1.done ? 1 : 0;
    for (int cy = 2; cy <= 4 && dcyc == 0; cy++) begin
      @(posedge clk); #1;
      if (cy == 2) s2 = snap(); else s3 = snap();
      if (done) dcyc = cy;
    end
    start = 0;
    if (dcyc != 0) begin @(posedge clk); #1; end
    s_after = snap();
  endtask

  task automatic test_reset();
    ctl_t idle;
    idle = '0; idle.waiting = 1;
    #3;
    vectors++;
    if (snap() !== idle) begin
      miscompares++; $display("FAIL reset_during: got %h want %h", snap(), idle);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    vectors++;
    if (snap() !== idle) begin
      miscompares++; $display("FAIL reset_after: got %h want %h", snap(), idle);
    end
  endtask

  task automatic test_directed();
    ctl_t s1, s2, s3, sa; int dc;
    run(32'hE2821005, 32'h0, 0, 0, s1, s2, s3, dc, sa);
    vectors++;
    if ({dc, s1.en_A, s1.A_addr} !== {32'd3, 1'b1, 4'd2}) begin
      miscompares++; $display("FAIL add_decode: got dc=%0d en_A=%b A=%0d want 3 1 2", dc, s1.en_A, s1.A_addr);
    end
    vectors++;
    if ({s2.sel_B, s2.imme_data, s2.ALU_op, s2.w_en1, s2.w_addr1, s2.en_status} !==
        {1'b1, 32'd5, 3'b000, 1'b1, 4'd1, 1'b0}) begin
      miscompares++; $display("FAIL add_exec: got %h want sel_B=1 imm=5 alu=0 w_en1=1 w_addr1=1 en_status=0", s2);
    end
    run(32'hE3A004FF, 32'h0, 0, 0, s1, s2, s3, dc, sa);
    vectors++;
    if ({s2.sel_A, s2.imme_data, s2.w_addr1} !== {1'b1, 32'hFF000000, 4'd0}) begin
      miscompares++; $display("FAIL mov_exec: got sel_A=%b imm=%h wa=%0d want 1 ff000000 0", s2.sel_A, s2.imme_data, s2.w_addr1);
    end
    run(32'hE0843105, 32'h0, 0, 0, s1, s2, s3, dc, sa);
    vectors++;
    if ({s1.B_addr, s1.sel_shift, s1.shift_imme, s2.shift_op, s2.sel_B} !==
        {4'd5, 1'b0, 32'd2, 2'b00, 1'b0}) begin
      miscompares++; $display("FAIL add_lsl: got B=%0d ss=%b si=%0d op=%0d sB=%b want 5 0 2 0 0",
                              s1.B_addr, s1.sel_shift, s1.shift_imme, s2.shift_op, s2.sel_B);
    end
    run(32'hE1510001, 32'h0, 0, 0, s1, s2, s3, dc, sa);
    vectors++;
    if ({s2.en_status, s2.ALU_op, s2.w_en1} !== {1'b1, 3'b001, 1'b0}) begin
      miscompares++; $display("FAIL cmp_exec: got es=%b alu=%b w_en1=%b want 1 001 0", s2.en_status, s2.ALU_op, s2.w_en1);
    end
    run(32'hE3A00F01, 32'h0, 0, 0, s1, s2, s3, dc, sa);
    vectors++;
    if (s2.imme_data !== 32'h4) begin
      miscompares++; $display("FAIL rot15: got %h want 00000004", s2.imme_data);
    end
  endtask

  task automatic test_condition();
    ctl_t s1, s2, s3, sa; int dc;
    run(32'h12821005, 32'h40000000, 0, 0, s1, s2, s3, dc, sa);
    vectors++;
    if ({dc, s1, s2.illegal, s2.done} !== {32'd2, ctl_t'('0), 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL addne_skip: got dc=%0d s1=%h ill=%b want 2 0 0", dc, s1, s2.illegal);
    end
    run(32'h02821005, 32'h40000000, 0, 0, s1, s2, s3, dc, sa);
    vectors++;
    if ({dc, s2.w_en1, s2.w_addr1} !== {32'd3, 1'b1, 4'd1}) begin
      miscompares++; $display("FAIL addeq_exec: got dc=%0d w_en1=%b wa=%0d want 3 1 1", dc, s2.w_en1, s2.w_addr1);
    end
  endtask

  task automatic test_illegal();
    ctl_t s1, s2, s3, sa; int dc;
    logic [31:0] bad [4] = '{32'hE5912000, 32'hE282F005, 32'hE0843F15, 32'hF2821005};
    for (int k = 0; k < 4; k++) begin
      run(bad[k], 32'h0, 0, 0, s1, s2, s3, dc, sa);
      vectors++;
      if ({dc, s1, s2.done, s2.illegal} !== {32'd2, ctl_t'('0), 1'b1, 1'b1}) begin
        miscompares++; $display("FAIL illegal_%0d: got dc=%0d s1=%h done=%b ill=%b want 2 0 1 1",
                                k, dc, s1, s2.done, s2.illegal);
      end
    end
  endtask

  task automatic test_back_to_back();
    ctl_t s1, s2, s3, sa, e1, e2, e3; int dc, edc;
    logic [31:0] seq [3] = '{32'hE2821005, 32'h12821005, 32'hE1510001};
    for (int k = 0; k < 3; k++) begin
      run(seq[k], 32'h40000000, 0, 0, s1, s2, s3, dc, sa);
      model(seq[k], 32'h40000000, edc, e1, e2, e3);
      vectors++;
      if ({dc, s1, s2, sa.waiting} !== {edc, e1, e2, 1'b1}) begin
        miscompares++; $display("FAIL b2b_%0d: got dc=%0d s1=%h s2=%h want dc=%0d s1=%h s2=%h",
                                k, dc, s1, s2, edc, e1, e2);
      end
    end
  endtask

  task automatic test_busy_start();
    ctl_t s1, s2, s3, sa, e1, e2, e3; int dc, edc;
    run(32'hE2821005, 32'h0, 1, 32'hE3A004FF, s1, s2, s3, dc, sa);
    model(32'hE2821005, 32'h0, edc, e1, e2, e3);
    vectors++;
    if ({dc, s1, s2, s3} !== {edc, e1, e2, e3}) begin
      miscompares++; $display("FAIL busy_start: got dc=%0d s2=%h want dc=%0d s2=%h", dc, s2, edc, e2);
    end
  endtask

  task automatic test_reset_mid_exec();
    ctl_t idle;
    idle = '0; idle.waiting = 1;
    instr = 32'hE2821005; status_out = 0; start = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    vectors++;
    if (w_en1 !== 1'b1) begin
      miscompares++; $display("FAIL rst_pre_exec_w_en1: got %b want 1", w_en1);
    end
    #2 rst_n = 0;
    #1;
    vectors++;
    if (snap() !== idle) begin
      miscompares++; $display("FAIL rst_async: got %h want %h", snap(), idle);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    vectors++;
    if (snap() !== idle) begin
      miscompares++; $display("FAIL rst_recover: got %h want %h", snap(), idle);
    end
  endtask

  task automatic test_random();
    ctl_t s1, s2, s3, sa, e1, e2, e3, idle; int dc, edc;
    logic [31:0] ins, st;
    idle = '0; idle.waiting = 1;
    for (int t = 0; t < 300; t++) begin
      ins = $urandom;
      if ($urandom_range(3) != 0) ins[27:26] = 2'b00;
      if ($urandom_range(3) != 0) ins[24:21] = OPS[$urandom_range(6)];
      if ($urandom_range(7) != 0) ins[31:28] = 4'($urandom_range(14));
      st = $urandom;
      run(ins, st, 0, 0, s1, s2, s3, dc, sa);
      model(ins, st, edc, e1, e2, e3);
      vectors++;
      if (dc !== edc || s1 !== e1 || s2 !== e2 || (edc == 3 && s3 !== e3) || sa !== idle) begin
        miscompares++;
        $display("FAIL rand_%0d ins=%h st=%h: got dc=%0d s1=%h s2=%h s3=%h want dc=%0d s1=%h s2=%h s3=%h",
                 t, ins, st[31:28], dc, s1, s2, s3, edc, e1, e2, e3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_condition();
    test_illegal();
    test_back_to_back();
    test_busy_start();
    test_reset_mid_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dp_controller.md
# dp_controller

Multicycle control FSM for the ARM32 datapath. It accepts one data-processing instruction at a time, decodes it, and evaluates its condition code against the datapath status flags. It then sequences the datapath's register-load, execute and write-back strobes. It drives every control input of the datapath and consumes its `status_out`.

## Interface
Parameters
- none; widths are fixed by the ARM32 datapath.

Ports
- Clock and reset:
  - `clk`  in  1  single clock.
  - `rst_n`  in  1  reset, asynchronous and active-low.
- Instruction handshake and status:
  - `start`  in  1  accept `instr` when high while `waiting`=1.
  - `instr`  in  32  ARM data-processing instruction word.
  - `status_out`  in  32  datapath flags: N=[31], Z=[30], C=[29], V=[28].
  - `waiting`  out  1  high only in IDLE.
  - `done`  out  1  one-cycle pulse when an instruction retires.
  - `illegal`  out  1  high with `done` when the instruction was unsupported.
- Register-file controls:
  - `w_addr1` out 4, `w_en1` out 1, `w_addr2` out 4, `w_en2` out 1.
  - `A_addr` out 4, `B_addr` out 4, `shift_addr` out 4.
- Datapath mux and enable controls:
  - `sel_A_in` out 2, `sel_B_in` out 2, `sel_shift_in` out 1.
  - `en_A` out 1, `en_B` out 1, `en_S` out 1.
  - `shift_imme` out 32, `sel_shift` out 1, `shift_op` out 2.
  - `sel_A` out 1, `sel_B` out 1, `sel_post_shift` out 1.
  - `imme_data` out 32, `ALU_op` out 3, `en_status` out 1.

## Operation
- States: IDLE → DECODE → EXEC → DONE → IDLE.
- Short path: DECODE → DONE when the condition fails or the instruction is unsupported.
- IDLE:
  - `waiting`=1.
  - On `start`, latch `instr` into IR and go to DECODE. Otherwise stay.
- Decode fields: cond=IR[31:28], I=IR[25], opcode=IR[24:21], S=IR[20], Rn=IR[19:16], Rd=IR[15:12].
- Supported opcodes and `ALU_op`:
  - AND 0000 → 011
  - EOR 0001 → 101
  - SUB 0010 → 001
  - ADD 0100 → 000
  - CMP 1010 → 001; S forced to 1, no write.
  - ORR 1100 → 100
  - MOV 1101 → 000 with `sel_A`=1, so A=0.
- Unsupported, which sets `illegal`:
  - IR[27:26]≠00
  - any other opcode
  - cond=1111
  - Rd=15 on a writing opcode
  - register-shift form (IR[4]=1) with Rs=15
- Conditions:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1.
- DECODE:
  - Evaluate legality, then the condition from `status_out` in this cycle.
  - If legal and the condition passes, drive `en_A`=1, `en_B`=1, `en_S`=1, `sel_A_in`=00, `sel_B_in`=00, `A_addr`=Rn, `B_addr`=IR[3:0], `shift_addr`=IR[11:8].
  - `sel_shift`=IR[4] when I=0; 0 when I=1.
  - `shift_imme`={27'b0, IR[11:7]}.
  - Then go to EXEC.
- EXEC:
  - `shift_op`=IR[6:5] when I=0, else 00.
  - `sel_B`=I; `imme_data`=ROR({24'b0,IR[7:0]}, 2·IR[11:8]); `sel_post_shift`=0.
  - `sel_A` as above; `ALU_op` as above.
  - `en_status`=S.
  - `w_en1`=1 and `w_addr1`=Rd, except for CMP.
  - Then go to DONE.
- DONE: `done`=1 for one cycle, `illegal` per decode, then go to IDLE.
- Constant outputs:
  - `w_en2`=0, `w_addr2`=0, `sel_shift_in`=0.
  - Every strobe (`en_*`, `w_en1`) is 0 outside the state that names it.
  - Address and select outputs are 0 outside DECODE/EXEC.

## Timing
- Reset values:
  - state=IDLE, IR=0, `waiting`=1.
  - Every other output 0; `imme_data`, `shift_imme`, `ALU_op` are 0.
- Reset mid-operation: immediate return to IDLE, with all strobes deasserted asynchronously. No write or flag update occurs after `rst_n` falls.
- Latency:
  - Accept edge at cycle 0.
  - DECODE in cycle 1, EXEC in cycle 2, `done` in cycle 3.
  - Skipped or illegal instruction: `done` in cycle 2.
  - Next accept is possible in cycle 4 (or cycle 3 for a skipped instruction).
- `start` while `waiting`=0 is ignored; IR holds.
- The condition is sampled from `status_out` during DECODE. A preceding EXEC flag write lands at least 2 cycles earlier, so no forwarding is needed.
- Rotation amount 0 yields imm8 unchanged; rotation 15 yields ROR by 30.

## Test plan
- ADD R1,R2,#5 (0xE2821005):
  - DECODE: `en_A`=1, `A_addr`=2.
  - EXEC: `sel_B`=1, `imme_data`=5, `ALU_op`=000, `w_en1`=1, `w_addr1`=1, `en_status`=0.
  - `done` in cycle 3.
- MOV R0,#0xFF000000 (0xE3A004FF): EXEC `sel_A`=1, `imme_data`=0xFF000000, `w_addr1`=0.
- ADD R3,R4,R5,LSL #2 (0xE0843105): DECODE `B_addr`=5, `sel_shift`=0, `shift_imme`=2; EXEC `shift_op`=00, `sel_B`=0.
- Condition handling:
  - With `status_out`=0x40000000, ADDNE (0x12821005) gets `done` in cycle 2 and no strobes.
  - ADDEQ (0x02821005) executes normally.
- CMP R1,R1 (0xE1510001): EXEC `en_status`=1, `ALU_op`=001, `w_en1`=0. LDR word 0xE5912000 gives `illegal`=1 with `done` in cycle 2.
- Drop `rst_n` low during EXEC of the ADD above: `w_en1` falls without a clock, state=IDLE, `waiting`=1. A `start` while busy is ignored.
